// File: rtl/angle_pkg.sv
// Shared types and 4.8 fixed-point defaults for the angle sequencer.
package angle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    typedef enum logic {
        WRAP   = 1'b0,
        BOUNCE = 1'b1
    } mode_e;

    localparam int          DEF_INT_BITS   = 4;
    localparam int          DEF_FRAC_BITS  = 8;
    localparam logic [11:0] DEF_TWO_PI     = 12'h648;
    localparam logic [11:0] DEF_INIT_ANGLE = 12'h00a;
    localparam logic [11:0] DEF_INIT_STEP  = 12'h00a;

endpackage

// File: rtl/angle_axis.sv
// One rotation channel: angle/step registers plus wrap (and, with
// ANGLE_BOUNCE_EN defined, ping-pong) advance arithmetic.
module angle_axis
    import angle_pkg::*;
#(
    parameter int           W          = 12,
    parameter logic [W-1:0] TWO_PI     = DEF_TWO_PI,
    parameter logic [W-1:0] INIT_ANGLE = DEF_INIT_ANGLE,
    parameter logic [W-1:0] INIT_STEP  = DEF_INIT_STEP
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         adv,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_step,
    input  logic         cfg_mode,
    output logic [W-1:0] angle,
    output logic         wrap_pulse
);

    logic [W-1:0] step_q;
    logic [W:0]   nxt;   // {reversal/wrap flag, next angle}

    // One modulus subtraction, then clamp: covers steps at or beyond TWO_PI.
    function automatic logic [W:0] wrap_next(input logic [W-1:0] a, input logic [W-1:0] s);
        logic [W:0] sum;
        logic [W:0] red;
        sum = {1'b0, a} + {1'b0, s};
        if (sum >= {1'b0, TWO_PI}) begin
            red = sum - {1'b0, TWO_PI};
            if (red >= {1'b0, TWO_PI})
                red = {1'b0, TWO_PI - W'(1)};
            return {1'b1, red[W-1:0]};
        end
        return {1'b0, sum[W-1:0]};
    endfunction

`ifdef ANGLE_BOUNCE_EN
    mode_e mode_q;
    logic  dir_dn;
    logic  nxt_dir;

    function automatic logic [W:0] bounce_up(input logic [W-1:0] a, input logic [W-1:0] s);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, s};
        if (sum >= {1'b0, TWO_PI})
            return {1'b1, TWO_PI - W'(1)};
        return {1'b0, sum[W-1:0]};
    endfunction

    function automatic logic [W:0] bounce_dn(input logic [W-1:0] a, input logic [W-1:0] s);
        if (a < s)
            return {1'b1, {W{1'b0}}};
        return {1'b0, a - s};
    endfunction

    always_comb begin
        nxt     = wrap_next(angle, step_q);
        nxt_dir = 1'b0;
        if (mode_q == BOUNCE) begin
            nxt     = dir_dn ? bounce_dn(angle, step_q) : bounce_up(angle, step_q);
            nxt_dir = dir_dn ^ nxt[W];
        end
    end
`else
    logic unused_mode;
    assign unused_mode = cfg_mode;

    always_comb nxt = wrap_next(angle, step_q);
`endif

    // p1: registered angle and pulse, visible the cycle after the strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            angle      <= INIT_ANGLE;
            step_q     <= INIT_STEP;
            wrap_pulse <= 1'b0;
`ifdef ANGLE_BOUNCE_EN
            mode_q     <= WRAP;
            dir_dn     <= 1'b0;
`endif
        end else begin
            wrap_pulse <= adv & nxt[W];
            if (adv)
                angle <= nxt[W-1:0];
            if (cfg_we)
                step_q <= cfg_step;
`ifdef ANGLE_BOUNCE_EN
            if (cfg_we) begin
                mode_q <= mode_e'(cfg_mode);
                dir_dn <= 1'b0;
            end else if (adv) begin
                dir_dn <= nxt_dir;
            end
`endif
        end
    end

endmodule

// File: rtl/angle_sequencer.sv
// Frame-locked multi-channel rotation angle sequencer (IDLE/RUN/STEP).
// Define ANGLE_BOUNCE_EN to enable per-channel ping-pong mode.
module angle_sequencer
    import angle_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int INT_BITS  = DEF_INT_BITS,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter logic [INT_BITS+FRAC_BITS-1:0] TWO_PI     = DEF_TWO_PI,
    parameter logic [INT_BITS+FRAC_BITS-1:0] INIT_ANGLE = DEF_INIT_ANGLE,
    parameter logic [INT_BITS+FRAC_BITS-1:0] INIT_STEP  = DEF_INIT_STEP
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  frame_clk_rising_edge,
    input  logic                                  cmd_start,
    input  logic                                  cmd_stop,
    input  logic                                  cmd_step,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [$clog2(N_CH)-1:0]               cfg_ch,
    input  logic [INT_BITS+FRAC_BITS-1:0]         cfg_step,
    input  logic                                  cfg_mode,
    output logic [N_CH*(INT_BITS+FRAC_BITS)-1:0]  theta,
    output logic [N_CH-1:0]                       wrap_pulse,
    output logic                                  theta_valid,
    output logic                                  busy
);

    localparam int W = INT_BITS + FRAC_BITS;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] STEP = ST_STEP;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       adv_p0;
    logic       cfg_acc;
    logic       vld_p1;

    // A stop on the strobe cycle wins, so no advance leaks out of RUN/STEP.
    always_comb begin
        state_nxt = state;
        adv_p0    = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_stop) begin
                    if (cmd_start)
                        state_nxt = RUN;
                    else if (cmd_step)
                        state_nxt = STEP;
                end
            end
            RUN: begin
                if (cmd_stop)
                    state_nxt = IDLE;
                else
                    adv_p0 = frame_clk_rising_edge;
            end
            STEP: begin
                if (cmd_stop) begin
                    state_nxt = IDLE;
                end else if (frame_clk_rising_edge) begin
                    adv_p0    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config is held off on strobe cycles so it never races an advance.
    assign cfg_ready = !(frame_clk_rising_edge && (state == RUN || state == STEP));
    assign cfg_acc   = cfg_valid && cfg_ready && (int'(cfg_ch) < N_CH);
    assign busy      = (state != IDLE);

    // p1: state and valid register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= adv_p0;
        end
    end

    assign theta_valid = vld_p1;

    for (genvar c = 0; c < N_CH; c++) begin : g_axis
        angle_axis #(
            .W          (W),
            .TWO_PI     (TWO_PI),
            .INIT_ANGLE (INIT_ANGLE),
            .INIT_STEP  (INIT_STEP)
        ) u_axis (
            .Clk        (Clk),
            .Reset      (Reset),
            .adv        (adv_p0),
            .cfg_we     (cfg_acc && (int'(cfg_ch) == c)),
            .cfg_step   (cfg_step),
            .cfg_mode   (cfg_mode),
            .angle      (theta[c*W +: W]),
            .wrap_pulse (wrap_pulse[c])
        );
    end

endmodule

// File: tb/tb_angle_sequencer.sv
// Directed bench for angle_sequencer with default 4.8 parameters;
// bounce vectors apply when ANGLE_BOUNCE_EN is defined.
module tb_angle_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk_rising_edge;
    logic        cmd_start, cmd_stop, cmd_step;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [11:0] cfg_step;
    logic        cfg_mode;
    logic [35:0] theta;
    logic [2:0]  wrap_pulse;
    logic        theta_valid;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    angle_sequencer dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .frame_clk_rising_edge (frame_clk_rising_edge),
        .cmd_start             (cmd_start),
        .cmd_stop              (cmd_stop),
        .cmd_step              (cmd_step),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_ch                (cfg_ch),
        .cfg_step              (cfg_step),
        .cfg_mode              (cfg_mode),
        .theta                 (theta),
        .wrap_pulse            (wrap_pulse),
        .theta_valid           (theta_valid),
        .busy                  (busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [11:0] th(input int c);
        return theta[c*12 +: 12];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk_rising_edge = 1'b1;
        tick();
        frame_clk_rising_edge = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [11:0] st, input logic md);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_step  = st;
        cfg_mode  = md;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic cmd(input logic start, input logic stop, input logic stp);
        cmd_start = start;
        cmd_stop  = stop;
        cmd_step  = stp;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_step  = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk_rising_edge = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_step = 12'h000; cfg_mode = 1'b0;
        #1;
        do_reset();

        // reset state
        chk("rst_th0", th(0), 12'h00a);
        chk("rst_th1", th(1), 12'h00a);
        chk("rst_th2", th(2), 12'h00a);
        chk("rst_wrap", wrap_pulse, 3'b000);
        chk("rst_valid", theta_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);

        // idle holds angles
        frame();
        chk("idle_hold", th(0), 12'h00a);
        chk("idle_novalid", theta_valid, 1'b0);

        // run, three frames
        cmd(1'b1, 1'b0, 1'b0);
        chk("run_busy", busy, 1'b1);
        frame();
        chk("run_f1", th(0), 12'h014);
        chk("run_f1_valid", theta_valid, 1'b1);
        tick();
        chk("run_f1_valid_off", theta_valid, 1'b0);
        frame();
        chk("run_f2", th(0), 12'h01e);
        chk("run_f2_valid", theta_valid, 1'b1);
        tick();
        frame();
        chk("run_f3", th(0), 12'h028);
        chk("run_f3_valid", theta_valid, 1'b1);

        // config colliding with strobe: refused, then accepted next cycle
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 12'h60e; cfg_mode = 1'b0;
        frame_clk_rising_edge = 1'b1;
        #1;
        chk("cfg_ready_low", cfg_ready, 1'b0);
        tick();
        frame_clk_rising_edge = 1'b0;
        #1;
        chk("cfg_old_step", th(0), 12'h032);
        chk("cfg_ready_high", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk("cfg_angle_kept", th(0), 12'h032);
        frame();
        chk("cfg_new_step", th(0), 12'h640);
        chk("nowrap_pulse", wrap_pulse, 3'b000);
        chk("ch1_f5", th(1), 12'h03c);

        // wrap at TWO_PI
        cfg(2'd0, 12'h00a, 1'b0);
        frame();
        chk("wrap_th0", th(0), 12'h002);
        chk("wrap_pulse", wrap_pulse, 3'b001);
        tick();
        chk("wrap_pulse_1cyc", wrap_pulse, 3'b000);

        // out-of-range channel discarded
        cfg(2'd3, 12'h100, 1'b0);
        frame();
        chk("badch_th0", th(0), 12'h00c);
        chk("badch_th1", th(1), 12'h050);
        chk("badch_th2", th(2), 12'h050);

        // zero step holds
        cfg(2'd2, 12'h000, 1'b0);
        frame();
        chk("zstep_th2", th(2), 12'h050);
        chk("zstep_wrap", wrap_pulse, 3'b000);
        chk("zstep_th0", th(0), 12'h016);

        // oversized step: one subtraction then saturate
        cfg(2'd1, 12'hfff, 1'b0);
        frame();
        chk("sat_th1", th(1), 12'h647);
        chk("sat_wrap", wrap_pulse, 3'b010);
        chk("sat_th0", th(0), 12'h020);
        cfg(2'd1, 12'h00a, 1'b0);

        // stop coincident with strobe: no advance
        cmd_stop = 1'b1;
        frame();
        cmd_stop = 1'b0;
        chk("stop_th0", th(0), 12'h020);
        chk("stop_valid", theta_valid, 1'b0);
        chk("stop_busy", busy, 1'b0);

        // single step: one advance on first of two frames
        cmd(1'b0, 1'b0, 1'b1);
        chk("step_busy", busy, 1'b1);
        frame();
        chk("step_th0", th(0), 12'h02a);
        chk("step_th1_wrap", th(1), 12'h009);
        chk("step_wrap", wrap_pulse, 3'b010);
        chk("step_valid", theta_valid, 1'b1);
        chk("step_idle", busy, 1'b0);
        frame();
        chk("step_once", th(0), 12'h02a);
        chk("step_once_valid", theta_valid, 1'b0);

        // priorities
        cmd(1'b1, 1'b1, 1'b0);
        chk("prio_stop", busy, 1'b0);
        cmd(1'b1, 1'b0, 1'b1);
        chk("prio_start_busy", busy, 1'b1);
        frame();
        frame();
        chk("prio_run_two", th(0), 12'h03e);
        chk("prio_run_busy", busy, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("prio_stopped", busy, 1'b0);

        // step aborted by stop
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("abort_busy", busy, 1'b0);
        frame();
        chk("abort_hold", th(0), 12'h03e);

        // reset dominates a pending config
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 12'h100;
        Reset = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        Reset = 1'b0;
        chk("rstcfg_th0", th(0), 12'h00a);
        chk("rstcfg_busy", busy, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        frame();
        chk("rstcfg_step", th(0), 12'h014);
        do_reset();

`ifdef ANGLE_BOUNCE_EN
        cfg(2'd2, 12'h636, 1'b1);
        cfg(2'd1, 12'h63f, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        frame();
        chk("bnc_a_th1", th(1), 12'h647);
        chk("bnc_a_th2", th(2), 12'h640);
        chk("bnc_a_wrap", wrap_pulse, 3'b010);
        cfg(2'd2, 12'h010, 1'b1);
        frame();
        chk("bnc_b_th1", th(1), 12'h008);
        chk("bnc_b_th2", th(2), 12'h647);
        chk("bnc_b_wrap", wrap_pulse, 3'b100);
        frame();
        chk("bnc_c_th1", th(1), 12'h000);
        chk("bnc_c_th2", th(2), 12'h637);
        chk("bnc_c_wrap", wrap_pulse, 3'b010);
        frame();
        chk("bnc_d_th1", th(1), 12'h63f);
        chk("bnc_d_th2", th(2), 12'h627);
        chk("bnc_d_wrap", wrap_pulse, 3'b000);
`else
        cfg(2'd2, 12'h640, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        frame();
        chk("nomode_th2", th(2), 12'h002);
        chk("nomode_wrap", wrap_pulse, 3'b100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
